pair_incdec: RTL and testbench
==============================

PAIR_INCDEC -- requirements
Module: pair_incdec

Interface
REQ-001 Parameters: none.
REQ-002 clock  input  1  rising-edge clock shared with the register file.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request an operation; sampled only in IDLE.
REQ-005 op_dec  input  1  0 = increment pair, 1 = decrement pair; sampled with start.
REQ-006 pair_sel  input  2  0 = BC, 1 = DE, 2 = HL, 3 = invalid; sampled with start.
REQ-007 rf_out1_sel  output  3  register-file read select for the high byte.
REQ-008 rf_out2_sel  output  3  register-file read select for the low byte.
REQ-009 rf_out1  input  8  register-file read data for rf_out1_sel (combinational).
REQ-010 rf_out2  input  8  register-file read data for rf_out2_sel (combinational).
REQ-011 rf_data_in  output  8  register-file write data.
REQ-012 rf_data_in_sel  output  3  register-file write select.
REQ-013 rf_write_reg  output  1  register-file write enable; the write commits on the same rising edge.
REQ-014 busy  output  1  operation in progress.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  valid with done; 1 = invalid pair_sel, no writes made.
REQ-017 wrap  output  1  valid with done; 1 = 16-bit carry (FFFF->0000) or borrow (0000->FFFF).
REQ-018 result  output  16  new pair value; held from done until the next accepted start.

Function
REQ-019 Register indices: BC = high 0 / low 1; DE = high 2 / low 3; HL = high 4 / low 5.
REQ-020 The FSM states are IDLE, READ, WR_LO, WR_HI and DONE; all control outputs are decoded from the state register (Moore).
REQ-021 IDLE: busy=0, done=0, rf_write_reg=0, rf sel outputs=0.
REQ-021a IDLE, start=1 with pair_sel 0-2: latch pair_sel and op_dec, go to READ.
REQ-021b IDLE, start=1 with pair_sel 3: go directly to DONE with err=1, wrap=0 and result unchanged.
REQ-022 READ: busy=1; rf_out1_sel=high idx, rf_out2_sel=low idx; capture operand={rf_out1,rf_out2}; compute new value = operand+1 or operand-1 mod 2^16; set wrap; go to WR_LO.
REQ-023 WR_LO: busy=1, rf_write_reg=1, rf_data_in_sel=low idx, rf_data_in=new[7:0]; go to WR_HI.
REQ-024 WR_HI: busy=1, rf_write_reg=1, rf_data_in_sel=high idx, rf_data_in=new[15:8]; load result=new; go to DONE.
REQ-025 DONE: busy=0, done=1 for exactly one cycle, err=0 for valid ops; go to IDLE.
REQ-026 Fixed latency: start accepted at edge N -> writes at edges N+2 (low) and N+3 (high) -> done high during cycle N+4.
REQ-027 A high byte equal to its old value is still written; write count is always 2 for a valid op and 0 for an invalid one.
REQ-028 start while busy, or in DONE, is ignored and not queued.
REQ-029 rf_write_reg is never high outside WR_LO and WR_HI.
REQ-030 rf_data_in and rf_data_in_sel are 0 when rf_write_reg=0.
REQ-031 Register-file index 6 is never driven on any select output.

Reset
REQ-032 reset_n=0 at a rising edge forces IDLE.
REQ-032a Reset sets busy, done, err, wrap and rf_write_reg to 0, all select/data outputs to 0, and result to 0000.
REQ-033 Reset in READ or WR_LO: no further writes occur.
REQ-033a Reset in WR_HI: the high-byte write is still committed at that edge only if reset_n=1; with reset_n=0 the write is suppressed, leaving the low byte already written (partial update is accepted).
REQ-034 start is ignored while reset_n=0 and is accepted from the first edge with reset_n=1.

Verification
REQ-035 BC=12FF, start inc pair 0 -> C=00 at N+2, B=13 at N+3, done at N+4, result=1300, wrap=0, err=0.
REQ-036 HL=FFFF, inc pair 2 -> L=00, H=00, result=0000, wrap=1; DE=0000, dec pair 1 -> E=FF, D=FF, result=FFFF, wrap=1.
REQ-037 start with pair_sel=3 -> done next cycle with err=1, zero rf_write_reg pulses, result unchanged.
REQ-038 start pulsed every cycle for 10 cycles with DE=0010 inc -> exactly 2 ops execute (accepted at cycles 0 and 5), DE=0012.
REQ-039 reset_n=0 during WR_HI of HL=00FF inc -> L=00, H=00 unchanged, busy=0, result=0000, no done pulse.
REQ-040 Back-to-back: start asserted in the cycle after done -> second op accepted, done spacing exactly 5 cycles.

Source files
------------

// File: rtl/pair_incdec.sv
// pair_incdec: increments or decrements a 16-bit register pair (BC/DE/HL) through
// a shared register file using one read cycle and two single-byte write cycles.
module pair_incdec (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op_dec,
    input  logic [1:0]  pair_sel,
    output logic [2:0]  rf_out1_sel,
    output logic [2:0]  rf_out2_sel,
    input  logic [7:0]  rf_out1,
    input  logic [7:0]  rf_out2,
    output logic [7:0]  rf_data_in,
    output logic [2:0]  rf_data_in_sel,
    output logic        rf_write_reg,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wrap,
    output logic [15:0] result
);
    typedef enum logic [2:0] {IDLE, READ, WR_LO, WR_HI, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  pair;
    logic        dec, err_r, wrap_r, we;
    logic [15:0] value, operand, next_val;
    logic [2:0]  hi_idx, lo_idx;
    logic        carry;

    assign hi_idx   = {pair, 1'b0};
    assign lo_idx   = {pair, 1'b1};
    assign operand  = {rf_out1, rf_out2};
    assign next_val = dec ? operand - 16'd1 : operand + 16'd1;
    assign carry    = dec ? (operand == 16'h0000) : (operand == 16'hFFFF);
    assign err      = done & err_r;
    assign wrap     = done & wrap_r;

    always_ff @(posedge clock)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx       = state;
        busy           = 1'b0;
        done           = 1'b0;
        we             = 1'b0;
        rf_out1_sel    = 3'd0;
        rf_out2_sel    = 3'd0;
        rf_data_in_sel = 3'd0;
        rf_data_in     = 8'd0;
        case (state)
            IDLE:  if (start) state_nx = (pair_sel == 2'd3) ? DONE : READ;
            READ: begin
                busy        = 1'b1;
                rf_out1_sel = hi_idx;
                rf_out2_sel = lo_idx;
                state_nx    = WR_LO;
            end
            WR_LO: begin
                busy           = 1'b1;
                we             = 1'b1;
                rf_data_in_sel = lo_idx;
                rf_data_in     = value[7:0];
                state_nx       = WR_HI;
            end
            WR_HI: begin
                busy           = 1'b1;
                we             = 1'b1;
                rf_data_in_sel = hi_idx;
                rf_data_in     = value[15:8];
                state_nx       = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // a reset edge must not commit a pending write, so the enable is qualified by reset_n
        rf_write_reg = we & reset_n;
        if (!rf_write_reg) begin
            rf_data_in     = 8'd0;
            rf_data_in_sel = 3'd0;
        end
    end

    always_ff @(posedge clock)
        if (!reset_n) begin
            pair   <= 2'd0;
            dec    <= 1'b0;
            value  <= 16'd0;
            err_r  <= 1'b0;
            wrap_r <= 1'b0;
            result <= 16'd0;
        end else begin
            if (state == IDLE && start) begin
                pair   <= pair_sel;
                dec    <= op_dec;
                err_r  <= &pair_sel;
                wrap_r <= 1'b0;
            end
            if (state == READ) begin
                value  <= next_val;
                wrap_r <= carry;
            end
            if (state == WR_HI) result <= value;
        end
endmodule

// File: tb/tb_pair_incdec.sv
// tb_pair_incdec: random and directed pair inc/dec operations against a register
// file model and an arithmetic reference of the expected pair values.
module tb_pair_incdec;
    logic        clock = 1'b0;
    logic        reset_n, start, op_dec;
    logic [1:0]  pair_sel;
    logic [2:0]  rf_out1_sel, rf_out2_sel, rf_data_in_sel;
    logic [7:0]  rf_out1, rf_out2, rf_data_in;
    logic        rf_write_reg, busy, done, err, wrap;
    logic [15:0] result;

    logic [7:0]  rf [8];
    logic [7:0]  rf_init [8];
    logic [7:0]  mrf [8];
    logic        ld = 1'b0;
    int          wr_total = 0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] e_result = 16'd0;
    logic        e_err, e_wrap;
    int          e_wr;
    int          last_done = 0;

    pair_incdec dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op_dec(op_dec), .pair_sel(pair_sel),
        .rf_out1_sel(rf_out1_sel), .rf_out2_sel(rf_out2_sel), .rf_out1(rf_out1), .rf_out2(rf_out2),
        .rf_data_in(rf_data_in), .rf_data_in_sel(rf_data_in_sel), .rf_write_reg(rf_write_reg),
        .busy(busy), .done(done), .err(err), .wrap(wrap), .result(result)
    );

    always #5 clock = ~clock;

    assign rf_out1 = rf[rf_out1_sel];
    assign rf_out2 = rf[rf_out2_sel];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ld) rf <= rf_init;
        else if (rf_write_reg) begin
            rf[rf_data_in_sel] <= rf_data_in;
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // select 6, write data without enable, write outside busy, busy with done
    always @(negedge clock)
        if (cyc > 1)
            check("invariant", {63'd0, rf_out1_sel == 3'd6 || rf_out2_sel == 3'd6 || rf_data_in_sel == 3'd6 ||
                  (!rf_write_reg && (rf_data_in != 8'd0 || rf_data_in_sel != 3'd0)) ||
                  (rf_write_reg && !busy) || (busy && done)}, 64'd0);

    function automatic void model(input logic [1:0] p, input logic d);
        int old, v;
        e_err  = (p == 2'd3);
        e_wrap = 1'b0;
        e_wr   = 0;
        if (p == 2'd3) return;
        old = int'(mrf[2*p]) * 256 + int'(mrf[2*p+1]);
        v = old + (d ? -1 : 1);
        e_wrap = (v < 0) || (v > 65535);
        v = (v + 65536) % 65536;
        mrf[2*p]   = 8'(v / 256);
        mrf[2*p+1] = 8'(v % 256);
        e_result = 16'(v);
        e_wr = 2;
    endfunction

    task automatic load();
        rf_init = mrf;
        ld = 1'b1;
        @(posedge clock); #1;
        ld = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 6; i++) check($sformatf("%s_r%0d", tag, i), {56'd0, rf[i]}, {56'd0, mrf[i]});
    endtask

    task automatic run_op(input logic [1:0] p, input logic d, input string tag);
        int c, w0;
        model(p, d);
        w0 = wr_total;
        start = 1'b1; pair_sel = p; op_dec = d;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_busy"}, {63'd0, busy}, {63'd0, p != 2'd3});
        c = 0;
        while (!done && c < 12) begin
            @(posedge clock); #1;
            c++;
        end
        last_done = cyc;
        check({tag, "_lat"}, 64'(c), (p == 2'd3) ? 64'd0 : 64'd3);
        check({tag, "_err"}, {63'd0, err}, {63'd0, e_err});
        check({tag, "_wrap"}, {63'd0, wrap}, {63'd0, e_wrap});
        check({tag, "_result"}, {48'd0, result}, {48'd0, e_result});
        check({tag, "_writes"}, 64'(wr_total - w0), 64'(e_wr));
        check_regs(tag);
        @(posedge clock); #1;
        check({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int dones, w0, t0;
        logic [15:0] pv;
        logic [1:0]  p;
        reset_n = 1'b0; start = 1'b0; op_dec = 1'b0; pair_sel = 2'd0;
        for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
        {mrf[0], mrf[1]} = 16'h12FF;
        {mrf[4], mrf[5]} = 16'hFFFF;
        load();
        @(posedge clock); #1;
        check("rst_state", {44'd0, busy, done, err, wrap, rf_write_reg, result}, 64'd0);
        start = 1'b1;
        w0 = wr_total;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ignore_start", {63'd0, busy}, 64'd0);
        check("rst_no_writes", 64'(wr_total - w0), 64'd0);
        reset_n = 1'b1;
        run_op(2'd0, 1'b0, "bc_inc");
        run_op(2'd2, 1'b0, "hl_wrap");
        run_op(2'd1, 1'b1, "de_borrow");
        run_op(2'd3, 1'b0, "invalid");
        t0 = last_done;
        run_op(2'd0, 1'b1, "b2b");
        check("b2b_spacing", 64'(last_done - t0), 64'd5);

        {mrf[2], mrf[3]} = 16'h0010;
        load();
        w0 = wr_total;
        dones = 0;
        start = 1'b1; pair_sel = 2'd1; op_dec = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            dones += int'(done);
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            dones += int'(done);
        end
        model(2'd1, 1'b0);
        model(2'd1, 1'b0);
        check("burst_dones", 64'(dones), 64'd2);
        check("burst_writes", 64'(wr_total - w0), 64'd4);
        check_regs("burst");

        {mrf[4], mrf[5]} = 16'h00FF;
        load();
        w0 = wr_total;
        start = 1'b1; pair_sel = 2'd2; op_dec = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        mrf[5] = 8'h00;
        e_result = 16'd0;
        check("rst_wrhi_busy", {63'd0, busy}, 64'd0);
        check("rst_wrhi_result", {48'd0, result}, 64'd0);
        check("rst_wrhi_writes", 64'(wr_total - w0), 64'd1);
        check_regs("rst_wrhi");
        @(posedge clock); #1;
        check("rst_wrhi_nodone", {63'd0, done}, 64'd0);
        reset_n = 1'b1;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = 2'($urandom_range(0, 2));
                case ($urandom_range(0, 4))
                    0: pv = 16'h0000;
                    1: pv = 16'hFFFF;
                    2: pv = 16'h00FF;
                    3: pv = 16'hFF00;
                    default: pv = 16'($urandom);
                endcase
                {mrf[2*p], mrf[2*p+1]} = pv;
                load();
            end
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
